arbitro_rr4: RTL and testbench

- Downstream consumer of four input FIFOs: pops one FIFO per cycle in round-robin order.
- Routes each retrieved word to one of four egress FIFOs, selected by the word's 2-bit destination field.
- Stalls all pops while any egress FIFO asserts pause, giving credit-style backpressure across the FIFO stage.
- Sits between the ingress FIFO bank and the egress FIFO bank of the switch datapath.

---
 rtl/arbitro_rr4_pkg.sv | 26 ++
 rtl/arbitro_rr4_grant4.sv | 34 +++
 rtl/arbitro_rr4.sv | 129 ++++++++++++
 tb/tb_arbitro_rr4.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_rr4_pkg.sv
// Shared constants and types for the four-port round-robin FIFO arbiter.
package arbitro_rr4_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int DEST_WIDTH = 2;
  localparam int IDX_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  // Destination field occupies the top DEST_WIDTH bits of each word.
  function automatic int dest_lsb(input int bus_size);
    return bus_size - DEST_WIDTH;
  endfunction

  function automatic logic [NUM_PORTS-1:0] dest_onehot(input logic [DEST_WIDTH-1:0] d);
    logic [NUM_PORTS-1:0] r;
    r    = '0;
    r[d] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/arbitro_rr4_grant4.sv
// Combinational rotating-priority search: first non-empty FIFO at or after i_ptr.
module rr_grant4
  import arbitro_rr4_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_empty,
  input  logic [IDX_W-1:0]     i_ptr,
  input  logic                 i_en,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_any
);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    if (i_en) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        w_cand = i_ptr + IDX_W'(k);
        if (!w_found && !i_empty[w_cand]) begin
          w_found       = 1'b1;
          o_gnt[w_cand] = 1'b1;
          o_idx         = w_cand;
        end
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/arbitro_rr4.sv
// Round-robin drain of four ingress FIFOs into four egress FIFOs, routed by
// destination field, with pop stall while any egress FIFO signals pause.
module arbitro_rr4
  import arbitro_rr4_pkg::*;
#(
  parameter int BUS_SIZE  = 6,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           empty_in,
  input  logic [3:0]           valid_in,
  input  logic [BUS_SIZE-1:0]  data_in0,
  input  logic [BUS_SIZE-1:0]  data_in1,
  input  logic [BUS_SIZE-1:0]  data_in2,
  input  logic [BUS_SIZE-1:0]  data_in3,
  input  logic [3:0]           pause_in,
  output logic [3:0]           pop_out,
  output logic [3:0]           push_out,
  output logic [BUS_SIZE-1:0]  data_out,
  output logic                 valid_out,
  output logic [1:0]           state_out,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  localparam int DLSB = dest_lsb(BUS_SIZE);

  state_t                              r_state, w_state_nxt;
  logic [IDX_W-1:0]                    r_rr_ptr;
  logic [IDX_W-1:0]                    r_sel;
  logic                                r_inflight;
  logic [NUM_PORTS-1:0]                r_push;
  logic [BUS_SIZE-1:0]                 r_data;
  logic                                r_valid;
  logic [CNT_WIDTH-1:0]                r_drop_cnt;

  logic [NUM_PORTS-1:0][BUS_SIZE-1:0]  w_data;
  logic [BUS_SIZE-1:0]                 w_word;
  logic                                w_word_vld;
  logic                                w_pause_any;
  logic                                w_all_empty;
  logic                                w_en;
  logic [NUM_PORTS-1:0]                w_gnt;
  logic [IDX_W-1:0]                    w_idx;
  logic                                w_any;

  assign w_data      = {data_in3, data_in2, data_in1, data_in0};
  assign w_pause_any = |pause_in;
  assign w_all_empty = &empty_in;

  // Gating on reset keeps pop low during the async reset window, not just after an edge.
  assign w_en = (r_state == ST_ACTIVE) && !w_pause_any && !reset;

  rr_grant4 u_grant (
    .i_empty (empty_in),
    .i_ptr   (r_rr_ptr),
    .i_en    (w_en),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign pop_out = w_gnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pause_any)       w_state_nxt = ST_PAUSED;
        else if (!w_all_empty) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_pause_any)      w_state_nxt = ST_PAUSED;
        else if (w_all_empty) w_state_nxt = ST_IDLE;
      end
      ST_PAUSED: begin
        if (!w_pause_any) w_state_nxt = w_all_empty ? ST_IDLE : ST_ACTIVE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_sel      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_any;
      if (w_any) begin
        r_sel    <= w_idx;
        r_rr_ptr <= w_idx + IDX_W'(1);
      end
    end
  end

  // Ingress FIFO output is valid the cycle after its pop, so read it via the latched select.
  assign w_word     = w_data[r_sel];
  assign w_word_vld = valid_in[r_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_push     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_push <= '0;
      if (r_inflight) begin
        if (w_word_vld) begin
          r_data  <= w_word;
          r_valid <= 1'b1;
          r_push  <= dest_onehot(w_word[DLSB +: DEST_WIDTH]);
        end else if (r_drop_cnt != {CNT_WIDTH{1'b1}}) begin
          r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign push_out  = r_push;
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign state_out = r_state;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_arbitro_rr4.sv
// Directed bench for arbitro_rr4: per-cycle vector table plus FIFO-model sequences.
module tb_arbitro_rr4;

  logic       clk, reset;
  logic [3:0] empty_in, valid_in, pause_in;
  logic [5:0] data_in0, data_in1, data_in2, data_in3;
  logic [3:0] pop_out, push_out;
  logic [5:0] data_out;
  logic       valid_out;
  logic [1:0] state_out;
  logic [7:0] drop_cnt;

  int n_vec, n_bad;

  arbitro_rr4 #(.BUS_SIZE(6), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .empty_in(empty_in), .valid_in(valid_in),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .pause_in(pause_in), .pop_out(pop_out), .push_out(push_out), .data_out(data_out),
    .valid_out(valid_out), .state_out(state_out), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] empty, valid, pause;
    logic [5:0] din;
    logic [3:0] pop, push;
    logic [5:0] dout;
    logic       vout;
    logic [1:0] st;
    logic [7:0] drop;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] e, v, p, input logic [5:0] d,
                     input logic [3:0] pp, ph, input logic [5:0] dout,
                     input logic vo, input logic [1:0] st, input logic [7:0] dr);
    vec_t t;
    t.empty = e; t.valid = v; t.pause = p; t.din = d;
    t.pop = pp; t.push = ph; t.dout = dout; t.vout = vo; t.st = st; t.drop = dr;
    tbl.push_back(t);
  endtask

  // Ingress FIFO model state for multi-cycle sequences
  int         cnt[4];
  int         rd[4];
  logic [5:0] mem[4][2];
  int         pop_q[$], popc_q[$], pushc_q[$];
  logic [5:0] pushd_q[$];
  logic [3:0] pusho_q[$];

  task automatic run_fifo(input int ncyc);
    logic [3:0] nv;
    logic [5:0] nd[4];
    pop_q.delete(); popc_q.delete(); pushc_q.delete(); pushd_q.delete(); pusho_q.delete();
    nv = 4'b0;
    for (int i = 0; i < 4; i++) begin rd[i] = 0; nd[i] = 6'h0; end
    pause_in = 4'b0;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 4; i++) empty_in[i] = (cnt[i] == 0);
      valid_in = nv;
      data_in0 = nd[0]; data_in1 = nd[1]; data_in2 = nd[2]; data_in3 = nd[3];
      #1;
      nv = 4'b0;
      if (pop_out != 4'b0) begin
        chk("pop_onehot", 32'($onehot(pop_out)), 1);
        for (int i = 0; i < 4; i++) if (pop_out[i]) begin
          pop_q.push_back(i);
          popc_q.push_back(c);
          chk("pop_nonempty", 32'(cnt[i] != 0), 1);
          if (cnt[i] != 0) begin
            nv[i] = 1'b1;
            nd[i] = mem[i][rd[i]];
            rd[i]++;
            cnt[i]--;
          end
        end
      end
      if (push_out != 4'b0) begin
        pushd_q.push_back(data_out);
        pusho_q.push_back(push_out);
        pushc_q.push_back(c);
      end
      @(negedge clk);
    end
    valid_in = 4'b0;
  endtask

  task automatic check_run(input string tag, input int n, input int ep[8],
                           input logic [5:0] ed[8], input logic [3:0] eo[8]);
    chk({tag, "_npop"}, pop_q.size(), n);
    chk({tag, "_npush"}, pushd_q.size(), n);
    for (int j = 0; j < n; j++) begin
      if (j < pop_q.size()) begin
        chk({tag, "_pop_idx"}, pop_q[j], ep[j]);
        chk({tag, "_pop_cyc"}, popc_q[j], popc_q[0] + j);
      end
      if (j < pushd_q.size()) begin
        chk({tag, "_push_data"}, pushd_q[j], ed[j]);
        chk({tag, "_push_oh"}, pusho_q[j], eo[j]);
        if (j < popc_q.size()) chk({tag, "_latency"}, pushc_q[j], popc_q[j] + 2);
      end
    end
  endtask

  initial begin
    int         ep[8];
    logic [5:0] ed[8];
    logic [3:0] eo[8];
    logic [3:0] seen;
    n_vec = 0; n_bad = 0;
    reset = 1'b1; empty_in = 4'b0000; valid_in = 4'b0; pause_in = 4'b0;
    data_in0 = 6'h0; data_in1 = 6'h0; data_in2 = 6'h0; data_in3 = 6'h0;

    //    empty    valid    pause    din        pop      push     dout       v  st  drop
    add(4'b1111, 4'b0000, 4'b0000, 6'b000000, 4'b0000, 4'b0000, 6'b000000, 0, 0, 0);
    add(4'b1011, 4'b0000, 4'b0000, 6'b000000, 4'b0000, 4'b0000, 6'b000000, 0, 0, 0);
    add(4'b1011, 4'b0000, 4'b0000, 6'b000000, 4'b0100, 4'b0000, 6'b000000, 0, 1, 0);
    add(4'b1111, 4'b0100, 4'b0000, 6'b010101, 4'b0000, 4'b0000, 6'b000000, 0, 1, 0);
    add(4'b1111, 4'b0000, 4'b0000, 6'b000000, 4'b0000, 4'b0010, 6'b010101, 1, 0, 0);
    add(4'b1111, 4'b0000, 4'b0000, 6'b000000, 4'b0000, 4'b0000, 6'b010101, 1, 0, 0);
    add(4'b1110, 4'b0000, 4'b0000, 6'b000000, 4'b0000, 4'b0000, 6'b010101, 1, 0, 0);
    add(4'b1110, 4'b0000, 4'b0000, 6'b000000, 4'b0001, 4'b0000, 6'b010101, 1, 1, 0);
    add(4'b1110, 4'b0001, 4'b0010, 6'b110011, 4'b0000, 4'b0000, 6'b010101, 1, 1, 0);
    add(4'b1110, 4'b0000, 4'b0010, 6'b000000, 4'b0000, 4'b1000, 6'b110011, 1, 2, 0);
    add(4'b1110, 4'b0000, 4'b0010, 6'b000000, 4'b0000, 4'b0000, 6'b110011, 1, 2, 0);
    add(4'b1110, 4'b0000, 4'b0000, 6'b000000, 4'b0000, 4'b0000, 6'b110011, 1, 2, 0);
    add(4'b1110, 4'b0000, 4'b0000, 6'b000000, 4'b0001, 4'b0000, 6'b110011, 1, 1, 0);
    add(4'b1111, 4'b0001, 4'b0000, 6'b001111, 4'b0000, 4'b0000, 6'b110011, 1, 1, 0);
    add(4'b1111, 4'b0000, 4'b0000, 6'b000000, 4'b0000, 4'b0001, 6'b001111, 1, 0, 0);
    add(4'b1111, 4'b0000, 4'b0000, 6'b000000, 4'b0000, 4'b0000, 6'b001111, 1, 0, 0);
    add(4'b0111, 4'b0000, 4'b0000, 6'b000000, 4'b0000, 4'b0000, 6'b001111, 1, 0, 0);
    add(4'b0111, 4'b0000, 4'b0000, 6'b000000, 4'b1000, 4'b0000, 6'b001111, 1, 1, 0);
    add(4'b1111, 4'b0000, 4'b0000, 6'b101010, 4'b0000, 4'b0000, 6'b001111, 1, 1, 0);
    add(4'b1111, 4'b0000, 4'b0000, 6'b000000, 4'b0000, 4'b0000, 6'b001111, 1, 0, 1);

    // Reset state, with non-empty FIFOs visible while reset is held
    @(negedge clk); #1;
    chk("rst_pop", pop_out, 0);
    chk("rst_push", push_out, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_vout", valid_out, 0);
    chk("rst_state", state_out, 0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[r]) begin
      empty_in = tbl[r].empty; valid_in = tbl[r].valid; pause_in = tbl[r].pause;
      data_in0 = tbl[r].din; data_in1 = tbl[r].din; data_in2 = tbl[r].din; data_in3 = tbl[r].din;
      #1;
      n_vec++;
      if (pop_out !== tbl[r].pop || push_out !== tbl[r].push || data_out !== tbl[r].dout ||
          valid_out !== tbl[r].vout || state_out !== tbl[r].st || drop_cnt !== tbl[r].drop) begin
        n_bad++;
        $display("FAIL row%0d: got pop=%b push=%b dout=%b v=%b st=%0d drop=%0d want pop=%b push=%b dout=%b v=%b st=%0d drop=%0d",
                 r, pop_out, push_out, data_out, valid_out, state_out, drop_cnt,
                 tbl[r].pop, tbl[r].push, tbl[r].dout, tbl[r].vout, tbl[r].st, tbl[r].drop);
      end
      @(negedge clk);
    end

    // Drop counter saturation: FIFO 3 popped every cycle, always invalid
    empty_in = 4'b0111; valid_in = 4'b0; pause_in = 4'b0; seen = 4'b0;
    for (int c = 0; c < 300; c++) begin
      #1; seen |= push_out;
      @(negedge clk);
    end
    empty_in = 4'b1111;
    repeat (3) @(negedge clk);
    #1;
    chk("sat_drop", drop_cnt, 8'd255);
    chk("sat_nopush", seen, 0);
    chk("sat_state", state_out, 0);
    @(negedge clk);

    // All four FIFOs with two words each
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 2;
      for (int k = 0; k < 2; k++) mem[i][k] = 6'((3 - i) * 16 + k * 4 + i);
    end
    ep = '{0, 1, 2, 3, 0, 1, 2, 3};
    ed = '{6'b110000, 6'b100001, 6'b010010, 6'b000011,
           6'b110100, 6'b100101, 6'b010110, 6'b000111};
    eo = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    run_fifo(14);
    check_run("rr4", 8, ep, ed, eo);

    // FIFOs 0 and 3 only, all words headed for egress 3
    cnt = '{2, 0, 0, 2};
    mem[0][0] = 6'b110001; mem[0][1] = 6'b110010;
    mem[3][0] = 6'b111100; mem[3][1] = 6'b111101;
    ep = '{0, 3, 0, 3, 0, 0, 0, 0};
    ed = '{6'b110001, 6'b111100, 6'b110010, 6'b111101, 6'h0, 6'h0, 6'h0, 6'h0};
    eo = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0};
    run_fifo(10);
    check_run("alt03", 4, ep, ed, eo);

    // Async reset between a pop of FIFO 0 and its push
    empty_in = 4'b1110; valid_in = 4'b0; pause_in = 4'b0;
    #1; chk("ar_idle", state_out, 0);
    @(negedge clk); #1;
    chk("ar_pop", pop_out, 4'b0001);
    @(negedge clk);
    empty_in = 4'b1111; valid_in = 4'b0001; data_in0 = 6'b111111;
    #2 reset = 1'b1;
    #1;
    chk("ar_push", push_out, 0);
    chk("ar_dout", data_out, 0);
    chk("ar_vout", valid_out, 0);
    chk("ar_state", state_out, 0);
    chk("ar_drop", drop_cnt, 0);
    chk("ar_pop0", pop_out, 0);
    @(posedge clk); #1;
    chk("ar_push_edge", push_out, 0);
    @(negedge clk);
    reset = 1'b0; empty_in = 4'b1100; valid_in = 4'b0;
    #1; chk("ar_rel_pop", pop_out, 0);
    @(negedge clk); #1;
    chk("ar_first_gnt", pop_out, 4'b0001);
    @(negedge clk); #1;
    chk("ar_second_gnt", pop_out, 4'b0010);
    empty_in = 4'b1111;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
